// File: rtl/ext_ram_ctrl_if.sv
// rtl/ext_ram_ctrl_if.sv - CPU request/ack, clear control and SRAM pin bundle
// The controller takes the slave side; the requester and RAM model take the master side.
interface ext_ram_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          REQ;
  logic          WR;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] WDATA;
  logic [DW-1:0] RDATA;
  logic          ACK;
  logic          BUSY;
  logic          CLR_START;
  logic [DW-1:0] CLR_VALUE;
  logic          CLR_DONE;
  logic [AW-1:0] RAM_ADR;
  logic [DW-1:0] RAM_D;
  logic [DW-1:0] RAM_Q;
  logic          RAM_ENB;
  logic          RAM_WEB;
  logic          RAM_OEB;

  modport slave (
    input  REQ, WR, ADDR, WDATA, CLR_START, CLR_VALUE, RAM_Q,
    output RDATA, ACK, BUSY, CLR_DONE, RAM_ADR, RAM_D, RAM_ENB, RAM_WEB, RAM_OEB
  );

  modport master (
    output REQ, WR, ADDR, WDATA, CLR_START, CLR_VALUE, RAM_Q,
    input  RDATA, ACK, BUSY, CLR_DONE, RAM_ADR, RAM_D, RAM_ENB, RAM_WEB, RAM_OEB
  );
endinterface

// File: rtl/ext_ram_ctrl.sv
// rtl/ext_ram_ctrl.sv - REQ/ACK to synchronous SPRAM sequencer with a whole-RAM clear engine
// Every output is a register; the comb process computes next values for all of them.
module ext_ram_ctrl #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic           CLK,
  input  logic           RST,
  ext_ram_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, CLEAR} state_t;

  localparam logic [AW-1:0] ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADR_LAST = {AW{1'b1}};

  state_t        state, state_n;
  logic          is_wr, is_wr_n;
  logic [AW-1:0] adr, adr_n;
  logic [DW-1:0] d, d_n;
  logic [DW-1:0] rdata, rdata_n;
  logic          enb, enb_n;
  logic          web, web_n;
  logic          oeb, oeb_n;
  logic          ack, ack_n;
  logic          busy;
  logic          done, done_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      is_wr <= 1'b0;
      adr   <= '0;
      d     <= '0;
      rdata <= '0;
      enb   <= 1'b1;
      web   <= 1'b1;
      oeb   <= 1'b1;
      ack   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      is_wr <= is_wr_n;
      adr   <= adr_n;
      d     <= d_n;
      rdata <= rdata_n;
      enb   <= enb_n;
      web   <= web_n;
      oeb   <= oeb_n;
      ack   <= ack_n;
      busy  <= (state_n != IDLE);
      done  <= done_n;
    end
  end

  // Strobes default inactive so each issue cycle asserts them for exactly one clock.
  always_comb begin
    state_n = state;
    is_wr_n = is_wr;
    adr_n   = adr;
    d_n     = d;
    rdata_n = rdata;
    enb_n   = 1'b1;
    web_n   = 1'b1;
    oeb_n   = 1'b1;
    ack_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CLR_START) begin
          d_n     = bus.CLR_VALUE;
          adr_n   = '0;
          enb_n   = 1'b0;
          web_n   = 1'b0;
          state_n = CLEAR;
        end else if (bus.REQ) begin
          adr_n   = bus.ADDR;
          d_n     = bus.WDATA;
          is_wr_n = bus.WR;
          enb_n   = 1'b0;
          web_n   = ~bus.WR;
          oeb_n   = bus.WR;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (is_wr) begin
          ack_n   = 1'b1;
          state_n = IDLE;
        end else begin
          // RAM drives Q after this edge; OEB stays low until it is captured.
          oeb_n   = 1'b0;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_n = bus.RAM_Q;
        ack_n   = 1'b1;
        state_n = IDLE;
      end
      CLEAR: begin
        if (adr == ADR_LAST) begin
          adr_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          adr_n = adr + ADR_ONE;
          enb_n = 1'b0;
          web_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.RAM_ADR  = adr;
  assign bus.RAM_D    = d;
  assign bus.RAM_ENB  = enb;
  assign bus.RAM_WEB  = web;
  assign bus.RAM_OEB  = oeb;
  assign bus.RDATA    = rdata;
  assign bus.ACK      = ack;
  assign bus.BUSY     = busy;
  assign bus.CLR_DONE = done;
endmodule

// File: tb/tb_ext_ram_ctrl.sv
// tb/tb_ext_ram_ctrl.sv - directed bench: full-size instance for accesses, AW=4 instance for clear
// Each instance drives a behavioural synchronous SPRAM model.
module tb_ext_ram_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  ext_ram_ctrl_if #(.AW(16), .DW(8)) bus16 ();
  ext_ram_ctrl_if #(.AW(4),  .DW(8)) bus4 ();

  ext_ram_ctrl #(.AW(16), .DW(8)) dut16 (.CLK(CLK), .RST(RST), .bus(bus16.slave));
  ext_ram_ctrl #(.AW(4),  .DW(8)) dut4  (.CLK(CLK), .RST(RST), .bus(bus4.slave));

  logic [7:0] mem16 [0:65535];
  logic [7:0] mem4  [0:15];
  logic [7:0] q16 = 8'h00;
  logic [7:0] q4  = 8'h00;

  always @(posedge CLK) begin
    if (!bus16.RAM_ENB) begin
      if (!bus16.RAM_WEB) mem16[bus16.RAM_ADR] <= bus16.RAM_D;
      else                q16 <= mem16[bus16.RAM_ADR];
    end
    if (!bus4.RAM_ENB) begin
      if (!bus4.RAM_WEB) mem4[bus4.RAM_ADR] <= bus4.RAM_D;
      else               q4 <= mem4[bus4.RAM_ADR];
    end
  end
  assign bus16.RAM_Q = bus16.RAM_OEB ? 8'hEE : q16;
  assign bus4.RAM_Q  = bus4.RAM_OEB  ? 8'hEE : q4;

  // One request/ack exchange; starts and ends on a falling edge, garbles inputs after acceptance.
  task automatic access(input bit sel, input bit wr, input logic [15:0] addr,
                        input logic [7:0] wdata, output int lat, output int web_low,
                        output logic [7:0] rd);
    logic got;
    got = 1'b0; lat = 0; web_low = 0;
    if (sel) begin
      bus4.REQ = 1'b1; bus4.WR = wr; bus4.ADDR = addr[3:0]; bus4.WDATA = wdata;
    end else begin
      bus16.REQ = 1'b1; bus16.WR = wr; bus16.ADDR = addr; bus16.WDATA = wdata;
    end
    while (!got && lat < 10) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if ((sel ? bus4.RAM_WEB : bus16.RAM_WEB) == 1'b0) web_low++;
      got = sel ? bus4.ACK : bus16.ACK;
      if (lat == 1) begin
        if (sel) begin bus4.ADDR = ~addr[3:0]; bus4.WDATA = ~wdata; end
        else     begin bus16.ADDR = ~addr;     bus16.WDATA = ~wdata; end
      end
    end
    if (sel) bus4.REQ = 1'b0; else bus16.REQ = 1'b0;
    rd = sel ? bus4.RDATA : bus16.RDATA;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({bus16.RAM_ENB, bus16.RAM_WEB, bus16.RAM_OEB, bus16.ACK, bus16.BUSY, bus16.CLR_DONE} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_ctl16 got %b want 111000",
               {bus16.RAM_ENB, bus16.RAM_WEB, bus16.RAM_OEB, bus16.ACK, bus16.BUSY, bus16.CLR_DONE});
    end
    checks++;
    if ({bus16.RAM_ADR, bus16.RAM_D, bus16.RDATA} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data16 got %h want 0", {bus16.RAM_ADR, bus16.RAM_D, bus16.RDATA});
    end
    checks++;
    if ({bus4.RAM_ENB, bus4.RAM_WEB, bus4.RAM_OEB, bus4.ACK, bus4.BUSY, bus4.CLR_DONE} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_ctl4 got %b want 111000",
               {bus4.RAM_ENB, bus4.RAM_WEB, bus4.RAM_OEB, bus4.ACK, bus4.BUSY, bus4.CLR_DONE});
    end
    RST = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, wl;
    logic [7:0] rd;
    access(1'b0, 1'b1, 16'h1234, 8'hA5, lat, wl, rd);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d want 2", lat); end
    checks++;
    if (wl !== 1) begin errors++; $display("FAIL write_web_cycles got %0d want 1", wl); end
    @(negedge CLK);
    access(1'b0, 1'b0, 16'h1234, 8'h00, lat, wl, rd);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d want 3", lat); end
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL read_data got %h want a5", rd); end
    checks++;
    if (wl !== 0) begin errors++; $display("FAIL read_web_cycles got %0d want 0", wl); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back(input bit wr, input int gap);
    int idx, cyc, last;
    idx = 0; cyc = 0; last = 0;
    bus16.REQ = 1'b1; bus16.WR = wr; bus16.ADDR = 16'h0000; bus16.WDATA = 8'h10;
    while (idx < 4 && cyc < 40) begin
      @(posedge CLK); cyc++;
      @(negedge CLK);
      checks++;
      if (!bus16.RAM_WEB && !bus16.RAM_OEB) begin
        errors++; $display("FAIL b2b_web_oeb_overlap cycle %0d", cyc);
      end
      if (bus16.ACK) begin
        checks++;
        if (cyc - last !== gap) begin
          errors++; $display("FAIL b2b_ack_gap wr=%0d idx=%0d got %0d want %0d", wr, idx, cyc - last, gap);
        end
        if (!wr) begin
          checks++;
          if (bus16.RDATA !== 8'h10 + 8'(idx)) begin
            errors++; $display("FAIL b2b_rdata idx=%0d got %h want %h", idx, bus16.RDATA, 8'h10 + 8'(idx));
          end
        end
        last = cyc; idx++;
        if (idx < 4) begin bus16.ADDR = 16'(idx); bus16.WDATA = 8'h10 + 8'(idx); end
        else bus16.REQ = 1'b0;
      end
    end
    bus16.REQ = 1'b0;
    checks++;
    if (idx !== 4) begin errors++; $display("FAIL b2b_ack_count wr=%0d got %0d want 4", wr, idx); end
    @(negedge CLK);
  endtask

  task automatic test_extremes();
    int lat, wl;
    logic [7:0] rd;
    access(1'b0, 1'b1, 16'hFFFF, 8'h3C, lat, wl, rd); @(negedge CLK);
    access(1'b0, 1'b1, 16'h0000, 8'hC3, lat, wl, rd); @(negedge CLK);
    access(1'b0, 1'b0, 16'hFFFF, 8'h00, lat, wl, rd);
    checks++;
    if (rd !== 8'h3C) begin errors++; $display("FAIL extreme_ffff got %h want 3c", rd); end
    @(negedge CLK);
    access(1'b0, 1'b0, 16'h0000, 8'h00, lat, wl, rd);
    checks++;
    if (rd !== 8'hC3) begin errors++; $display("FAIL extreme_0000 got %h want c3", rd); end
    @(negedge CLK);
  endtask

  task automatic test_clear();
    int busy_cnt, ack_busy, lat, wl;
    logic got;
    logic [7:0] rd;
    bus4.CLR_START = 1'b1; bus4.CLR_VALUE = 8'h5A;
    bus4.REQ = 1'b1; bus4.WR = 1'b0; bus4.ADDR = 4'h3;
    @(posedge CLK); @(negedge CLK);
    bus4.CLR_START = 1'b0; bus4.CLR_VALUE = 8'h00;
    busy_cnt = 0; ack_busy = 0;
    while (bus4.BUSY && busy_cnt < 40) begin
      busy_cnt++;
      if (bus4.ACK) ack_busy++;
      @(posedge CLK); @(negedge CLK);
    end
    checks++;
    if (busy_cnt !== 16) begin errors++; $display("FAIL clear_busy_cycles got %0d want 16", busy_cnt); end
    checks++;
    if (ack_busy !== 0) begin errors++; $display("FAIL clear_ack_while_busy got %0d want 0", ack_busy); end
    checks++;
    if (bus4.CLR_DONE !== 1'b1) begin errors++; $display("FAIL clear_done got %b want 1", bus4.CLR_DONE); end
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if (lat == 1) begin
        checks++;
        if (bus4.CLR_DONE !== 1'b0) begin errors++; $display("FAIL clear_done_pulse got %b want 0", bus4.CLR_DONE); end
      end
      got = bus4.ACK;
    end
    bus4.REQ = 1'b0;
    checks++;
    if (lat !== 3 || bus4.RDATA !== 8'h5A) begin
      errors++; $display("FAIL clear_pending_req lat %0d data %h want 3 5a", lat, bus4.RDATA);
    end
    @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 1'b0, 16'(i), 8'h00, lat, wl, rd);
      checks++;
      if (rd !== 8'h5A) begin errors++; $display("FAIL clear_readback addr %0d got %h want 5a", i, rd); end
      @(negedge CLK);
    end
  endtask

  task automatic test_abort_read();
    bus16.REQ = 1'b1; bus16.WR = 1'b0; bus16.ADDR = 16'h1234;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (bus16.BUSY !== 1'b1) begin errors++; $display("FAIL abort_read_accept got %b want 1", bus16.BUSY); end
    RST = 1'b1; bus16.REQ = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({bus16.RAM_ENB, bus16.RAM_WEB, bus16.RAM_OEB, bus16.ACK, bus16.BUSY, bus16.CLR_DONE,
         bus16.RAM_ADR, bus16.RAM_D, bus16.RDATA} !== {6'b111000, 32'h0}) begin
      errors++; $display("FAIL abort_read_reset got %b %h want 111000 0",
        {bus16.RAM_ENB, bus16.RAM_WEB, bus16.RAM_OEB, bus16.ACK, bus16.BUSY, bus16.CLR_DONE},
        {bus16.RAM_ADR, bus16.RAM_D, bus16.RDATA});
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (bus16.ACK !== 1'b0) begin errors++; $display("FAIL abort_read_ack cycle %0d got 1 want 0", i); end
    end
  endtask

  task automatic test_abort_clear();
    int n;
    bus4.CLR_START = 1'b1; bus4.CLR_VALUE = 8'h77;
    @(posedge CLK); @(negedge CLK);
    bus4.CLR_START = 1'b0;
    n = 0;
    while (bus4.RAM_ADR !== 4'h7 && n < 20) begin @(posedge CLK); @(negedge CLK); n++; end
    checks++;
    if (bus4.RAM_ADR !== 4'h7) begin errors++; $display("FAIL abort_clear_reach7 got %h want 7", bus4.RAM_ADR); end
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({bus4.RAM_ENB, bus4.RAM_WEB, bus4.RAM_OEB, bus4.ACK, bus4.BUSY, bus4.CLR_DONE,
         bus4.RAM_ADR, bus4.RAM_D} !== {6'b111000, 12'h0}) begin
      errors++; $display("FAIL abort_clear_reset got %b %h want 111000 0",
        {bus4.RAM_ENB, bus4.RAM_WEB, bus4.RAM_OEB, bus4.ACK, bus4.BUSY, bus4.CLR_DONE},
        {bus4.RAM_ADR, bus4.RAM_D});
    end
    RST = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (bus4.CLR_DONE || bus4.BUSY) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL abort_clear_done_or_busy got %0d cycles want 0", n); end
  endtask

  initial begin
    bus16.REQ = 1'b0; bus16.WR = 1'b0; bus16.ADDR = '0; bus16.WDATA = '0;
    bus16.CLR_START = 1'b0; bus16.CLR_VALUE = '0;
    bus4.REQ = 1'b0; bus4.WR = 1'b0; bus4.ADDR = '0; bus4.WDATA = '0;
    bus4.CLR_START = 1'b0; bus4.CLR_VALUE = '0;
    test_reset();
    test_write_read();
    test_back_to_back(1'b1, 2);
    test_back_to_back(1'b0, 3);
    test_extremes();
    test_clear();
    test_abort_read();
    test_abort_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
